hht_sparse_mem_responder: RTL and testbench
===========================================

Name: hht_sparse_mem_responder

Overview:
- Memory/register responder for the HHT control engine. It serves the engine's two read ports: port 1 is column-index data, port 2 is vector-value data.
- It also answers the engine's base-register lookups and is loaded by the CPU through a simple write port.
- It replaces the behavioural memory models with synthesizable, registered storage that sits between the CPU bus and the HHT control block.

Parameters:
- A_BASE, 180, first word address of column-index array (port 1)
- A_DEPTH, 128, words in column-index array
- B_BASE, 2, first word address of value array (port 2)
- B_DEPTH, 16, words in value array
- MISS_VAL, 99999, data returned for any unmapped address
- DW, 32, data/address width

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- mem_init  in  1  single-cycle pulse; starts a clear sweep of both arrays
- WR  in  1  CPU write strobe
- cpu_addr  in  DW  CPU write address, decoded into the A window, the B window, or ignored
- cpu_wdata  in  DW  CPU write data
- reg_wr  in  1  base-register write strobe
- reg_waddr  in  5  base-register index (6, 8, 9, 15 valid)
- reg_wdata  in  DW  base-register write data
- RD  in  1  read enable for both ports
- addr1  in  DW  port-1 read address
- addr2  in  DW  port-2 read address
- dataIn1  out  DW  port-1 read data, registered
- dataIn2  out  DW  port-2 read data, registered
- rvalid  out  1  dataIn1/dataIn2 valid this cycle
- regaddr1  in  5  base lookup A
- regaddr2  in  5  base lookup B
- base_dat_a  out  DW  reg6 if regaddr1==6, reg8 if ==8, else holds last value
- base_dat_b  out  DW  reg15 if regaddr2==15, reg9 if ==9, else holds last value
- ready  out  1  high when not clearing

Behaviour:
- Reset (Rst=0, async):
  - FSM enters CLEAR; sweep counter = 0.
  - dataIn1 = dataIn2 = MISS_VAL; rvalid = 0; ready = 0; base_dat_a = base_dat_b = 0.
  - Base regs 6, 8, 9, 15 = 0.
- FSM states CLEAR, READY:
  - CLEAR: each cycle writes 0 to A[cnt] (if cnt<A_DEPTH) and B[cnt] (if cnt<B_DEPTH), then cnt++.
  - CLEAR exits to READY in the cycle after cnt reaches max(A_DEPTH,B_DEPTH)-1. ready rises on that edge.
  - READY: mem_init=1 returns to CLEAR with cnt=0.
  - mem_init asserted during CLEAR restarts the sweep at cnt=0.
- CPU writes (READY only):
  - A_BASE<=cpu_addr<A_BASE+A_DEPTH writes A[cpu_addr-A_BASE].
  - B_BASE<=cpu_addr<B_BASE+B_DEPTH writes B[cpu_addr-B_BASE].
  - Any other address: no effect.
  - WR during CLEAR is dropped.
- Reads:
  - 1-cycle latency: RD sampled at edge N gives dataIn1/2 and rvalid=1 at edge N+1.
  - Out-of-window address gives MISS_VAL.
  - RD=0 gives rvalid=0, and dataIn1/2 hold their previous values.
  - RD during CLEAR: rvalid=1, data=MISS_VAL.
- Read/write collision: same cycle, same word, read returns old data (read-before-write). The new data is visible on the next read.
- Address compare uses the full 32 bits, unsigned. No wrap-around: an address just past the window end is a miss.
- Base registers:
  - reg_wr to index 6, 8, 9 or 15 updates that register at the edge; other indices are ignored. reg_wr is accepted in CLEAR as well.
  - base_dat_a/b are registered: lookup sampled at edge N appears at N+1.
  - An unmatched index holds the output.
  - Same-cycle reg_wr and lookup of the same index returns the old value.
- Reset mid-sweep or mid-read: all outputs return to reset values immediately; array contents are undefined until the next sweep completes.

Decomposition:
- Package hht_mem_pkg: state enum {CLEAR, READY}, MISS_VAL, and base-register index constants (IDX_COLBASE=6, IDX_VBASE=8, IDX_MBASE=9, IDX_ROWBASE=15).
- One sub-module, hht_sp_ram: parameterized single-write/single-read synchronous RAM with read-before-write. Instantiated twice, for A and B.
- Window decode, FSM and base register file stay in the top.

Test Plan:
- Reset, then wait: ready rises exactly 128 cycles after Rst deasserts; reads of addr1=180, addr2=2 return 0 with rvalid=1.
- CPU writes 180←1, 181←13, 2←48, 17←5; then RD with addr1=181, addr2=17 returns dataIn1=13, dataIn2=5 one cycle later.
- Reads at addr1=308 and addr1=179, and addr2=18 and addr2=1, all return 99999.
- Same-cycle write 3←81 and read addr2=3 return the old value 0; the next read returns 81.
- reg_wr 6←180, 8←2, 15←7; regaddr1=6 gives base_dat_a=180 next cycle; regaddr1=3 holds 180; regaddr2=15 gives 7.
- mem_init pulse after loading data: ready drops, a WR during the sweep is dropped, and after 128 cycles addr1=181 reads 0.
- Rst pulse mid-sweep: outputs go to reset values asynchronously.

Source files
------------

// File: rtl/hht_mem_pkg.sv
// hht_mem_pkg: shared state encoding, miss value and base-register indices
package hht_mem_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam logic [31:0] MISS_VAL = 32'd99999;
  localparam logic [4:0] IDX_COLBASE = 5'd6;
  localparam logic [4:0] IDX_VBASE = 5'd8;
  localparam logic [4:0] IDX_MBASE = 5'd9;
  localparam logic [4:0] IDX_ROWBASE = 5'd15;
endpackage

// File: rtl/hht_sp_ram.sv
// hht_sp_ram: one-write/one-read synchronous RAM, reads return pre-write data
module hht_sp_ram #(
  parameter int DEPTH = 16,
  parameter int DW = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  // write and registered read share the edge, so a colliding read sees old data
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/hht_sparse_mem_responder.sv
// hht_sparse_mem_responder: clearable column/value arrays and base registers for the HHT engine
module hht_sparse_mem_responder #(
  parameter int unsigned A_BASE = 180,
  parameter int unsigned A_DEPTH = 128,
  parameter int unsigned B_BASE = 2,
  parameter int unsigned B_DEPTH = 16,
  parameter int DW = 32,
  parameter logic [DW-1:0] MISS_VAL = hht_mem_pkg::MISS_VAL
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          mem_init,
  input  logic          WR,
  input  logic [DW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          reg_wr,
  input  logic [4:0]    reg_waddr,
  input  logic [DW-1:0] reg_wdata,
  input  logic          RD,
  input  logic [DW-1:0] addr1,
  input  logic [DW-1:0] addr2,
  output logic [DW-1:0] dataIn1,
  output logic [DW-1:0] dataIn2,
  output logic          rvalid,
  input  logic [4:0]    regaddr1,
  input  logic [4:0]    regaddr2,
  output logic [DW-1:0] base_dat_a,
  output logic [DW-1:0] base_dat_b,
  output logic          ready
);
  import hht_mem_pkg::*;
  localparam int unsigned CMAX = A_DEPTH > B_DEPTH ? A_DEPTH : B_DEPTH;
  localparam int AW = $clog2(A_DEPTH);
  localparam int BW = $clog2(B_DEPTH);
  localparam int CW = $clog2(CMAX) + 1;
  localparam logic [DW-1:0] A_LO = DW'(A_BASE);
  localparam logic [DW-1:0] A_HI = DW'(A_BASE + A_DEPTH);
  localparam logic [DW-1:0] B_LO = DW'(B_BASE);
  localparam logic [DW-1:0] B_HI = DW'(B_BASE + B_DEPTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic clr, wa, wb, ra, rb, hit1, hit2, a_we, b_we;
  logic [AW-1:0] a_waddr;
  logic [BW-1:0] b_waddr;
  logic [DW-1:0] a_wdata, b_wdata, a_q, b_q;
  logic [DW-1:0] reg6, reg8, reg9, reg15;
  assign clr = state == CLEAR;
  assign wa = cpu_addr >= A_LO && cpu_addr < A_HI;
  assign wb = cpu_addr >= B_LO && cpu_addr < B_HI;
  assign ra = addr1 >= A_LO && addr1 < A_HI;
  assign rb = addr2 >= B_LO && addr2 < B_HI;
  assign a_we = clr ? cnt < CW'(A_DEPTH) : WR && wa;
  assign b_we = clr ? cnt < CW'(B_DEPTH) : WR && wb;
  assign a_waddr = clr ? AW'(cnt) : AW'(cpu_addr - A_LO);
  assign b_waddr = clr ? BW'(cnt) : BW'(cpu_addr - B_LO);
  assign a_wdata = clr ? '0 : cpu_wdata;
  assign b_wdata = clr ? '0 : cpu_wdata;
  assign dataIn1 = hit1 ? a_q : MISS_VAL;
  assign dataIn2 = hit2 ? b_q : MISS_VAL;
  hht_sp_ram #(.DEPTH(A_DEPTH), .DW(DW)) u_ram_a (
    .clk(Clk), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .re(RD && !clr && ra), .raddr(AW'(addr1 - A_LO)), .rdata(a_q)
  );
  hht_sp_ram #(.DEPTH(B_DEPTH), .DW(DW)) u_ram_b (
    .clk(Clk), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .re(RD && !clr && rb), .raddr(BW'(addr2 - B_LO)), .rdata(b_q)
  );
  // clear sweep over both arrays, then serve until the next mem_init
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= CLEAR;
      cnt <= '0;
      ready <= 1'b0;
    end else if (mem_init) begin
      state <= CLEAR;
      cnt <= '0;
      ready <= 1'b0;
    end else if (clr) begin
      cnt <= cnt == CW'(CMAX - 1) ? '0 : cnt + CW'(1);
      if (cnt == CW'(CMAX - 1)) begin
        state <= READY;
        ready <= 1'b1;
      end
    end
  end
  // read qualifiers: hit flags hold with RD low so the data outputs hold too
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rvalid <= 1'b0;
      hit1 <= 1'b0;
      hit2 <= 1'b0;
    end else begin
      rvalid <= RD;
      if (RD) begin
        hit1 <= !clr && ra;
        hit2 <= !clr && rb;
      end
    end
  end
  // base register file, writable in any state
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      reg6 <= '0;
      reg8 <= '0;
      reg9 <= '0;
      reg15 <= '0;
    end else if (reg_wr) begin
      if (reg_waddr == IDX_COLBASE) reg6 <= reg_wdata;
      if (reg_waddr == IDX_VBASE) reg8 <= reg_wdata;
      if (reg_waddr == IDX_MBASE) reg9 <= reg_wdata;
      if (reg_waddr == IDX_ROWBASE) reg15 <= reg_wdata;
    end
  end
  // registered base lookups; unmatched indices keep the last value
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      base_dat_a <= '0;
      base_dat_b <= '0;
    end else begin
      base_dat_a <= regaddr1 == IDX_COLBASE ? reg6 : regaddr1 == IDX_VBASE ? reg8 : base_dat_a;
      base_dat_b <= regaddr2 == IDX_ROWBASE ? reg15 : regaddr2 == IDX_MBASE ? reg9 : base_dat_b;
    end
  end
endmodule

// File: tb/tb_hht_sparse_mem_responder.sv
// tb_hht_sparse_mem_responder: model-checked directed test of the sparse memory responder
module tb_hht_sparse_mem_responder;
  localparam int MISS = 99999;
  logic Clk = 0, Rst = 1, mem_init = 0, WR = 0, reg_wr = 0, RD = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, reg_wdata = 0, addr1 = 0, addr2 = 0;
  logic [4:0] reg_waddr = 0, regaddr1 = 0, regaddr2 = 0;
  logic [31:0] dataIn1, dataIn2, base_dat_a, base_dat_b;
  logic rvalid, ready;
  int total = 0, bad = 0, n;
  logic chk_en = 0;

  hht_sparse_mem_responder dut (
    .Clk(Clk), .Rst(Rst), .mem_init(mem_init), .WR(WR), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .reg_wr(reg_wr), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .RD(RD), .addr1(addr1), .addr2(addr2), .dataIn1(dataIn1), .dataIn2(dataIn2),
    .rvalid(rvalid), .regaddr1(regaddr1), .regaddr2(regaddr2),
    .base_dat_a(base_dat_a), .base_dat_b(base_dat_b), .ready(ready)
  );

  always #5 Clk = ~Clk;

  // behavioural model: window arithmetic, arrays indexed by offset, a countdown for the sweep
  logic [31:0] a_m [128];
  logic [31:0] b_m [16];
  logic [31:0] m_d1, m_d2, m_ba, m_bb, r6, r8, r9, r15;
  logic m_rv, m_ready;
  int left;

  function automatic bit in_a(logic [31:0] a);
    return a >= 180 && a < 308;
  endfunction
  function automatic bit in_b(logic [31:0] a);
    return a >= 2 && a < 18;
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_d1 <= MISS; m_d2 <= MISS; m_rv <= 0; m_ba <= 0; m_bb <= 0; m_ready <= 0;
      r6 <= 0; r8 <= 0; r9 <= 0; r15 <= 0; left <= 128;
      foreach (a_m[i]) a_m[i] <= 0;
      foreach (b_m[i]) b_m[i] <= 0;
    end else begin
      m_rv <= RD;
      if (RD) begin
        m_d1 <= (left == 0 && in_a(addr1)) ? a_m[addr1 - 180] : MISS;
        m_d2 <= (left == 0 && in_b(addr2)) ? b_m[addr2 - 2] : MISS;
      end
      if (regaddr1 == 6) m_ba <= r6; else if (regaddr1 == 8) m_ba <= r8;
      if (regaddr2 == 15) m_bb <= r15; else if (regaddr2 == 9) m_bb <= r9;
      if (reg_wr && reg_waddr == 6) r6 <= reg_wdata;
      if (reg_wr && reg_waddr == 8) r8 <= reg_wdata;
      if (reg_wr && reg_waddr == 9) r9 <= reg_wdata;
      if (reg_wr && reg_waddr == 15) r15 <= reg_wdata;
      if (left == 0 && WR && in_a(cpu_addr)) a_m[cpu_addr - 180] <= cpu_wdata;
      if (left == 0 && WR && in_b(cpu_addr)) b_m[cpu_addr - 2] <= cpu_wdata;
      if (mem_init) begin
        left <= 128; m_ready <= 0;
        foreach (a_m[i]) a_m[i] <= 0;
        foreach (b_m[i]) b_m[i] <= 0;
      end else if (left != 0) begin
        left <= left - 1; m_ready <= left == 1;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge Clk) if (chk_en) begin
    chk("m_dataIn1", dataIn1, m_d1);
    chk("m_dataIn2", dataIn2, m_d2);
    chk("m_rvalid", {31'b0, rvalid}, {31'b0, m_rv});
    chk("m_base_a", base_dat_a, m_ba);
    chk("m_base_b", base_dat_b, m_bb);
    chk("m_ready", {31'b0, ready}, {31'b0, m_ready});
  end

  task automatic wait_ready(output int cnt);
    cnt = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge Clk);
      if (ready) begin cnt = i; break; end
    end
  endtask

  task automatic wr(int a, int d);
    WR = 1; cpu_addr = a; cpu_wdata = d;
    @(negedge Clk);
    WR = 0;
  endtask

  task automatic rd(int a1, int a2);
    RD = 1; addr1 = a1; addr2 = a2;
    @(negedge Clk);
    RD = 0;
  endtask

  task automatic rw(int idx, int d);
    reg_wr = 1; reg_waddr = idx; reg_wdata = d;
    @(negedge Clk);
    reg_wr = 0;
  endtask

  initial begin
    #2 Rst = 0;
    #1;
    chk("rst_d1", dataIn1, MISS);
    chk("rst_rvalid", {31'b0, rvalid}, 0);
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_base_a", base_dat_a, 0);
    chk_en = 1;
    @(negedge Clk); @(negedge Clk);
    #2 Rst = 1;
    wait_ready(n);
    chk("ready_latency", n, 128);
    rd(180, 2);
    chk("clr_a180", dataIn1, 0);
    chk("clr_b2", dataIn2, 0);
    chk("clr_rvalid", {31'b0, rvalid}, 1);
    wr(180, 1); wr(181, 13); wr(2, 48); wr(17, 5); wr(500, 7); wr(308, 9);
    rd(181, 17);
    chk("rd_a181", dataIn1, 13);
    chk("rd_b17", dataIn2, 5);
    @(negedge Clk);
    chk("hold_d1", dataIn1, 13);
    chk("hold_rvalid", {31'b0, rvalid}, 0);
    rd(308, 18);
    chk("miss_a308", dataIn1, MISS);
    chk("miss_b18", dataIn2, MISS);
    rd(179, 1);
    chk("miss_a179", dataIn1, MISS);
    chk("miss_b1", dataIn2, MISS);
    rd(180, 2);
    chk("rd_a180", dataIn1, 1);
    chk("rd_b2", dataIn2, 48);
    WR = 1; cpu_addr = 3; cpu_wdata = 81;
    rd(180, 3);
    WR = 0;
    chk("coll_old", dataIn2, 0);
    rd(180, 3);
    chk("coll_new", dataIn2, 81);
    rw(6, 180); rw(8, 2); rw(15, 7); rw(7, 44);
    regaddr1 = 6; regaddr2 = 15;
    @(negedge Clk);
    chk("base_a6", base_dat_a, 180);
    chk("base_b15", base_dat_b, 7);
    regaddr1 = 3; regaddr2 = 0;
    @(negedge Clk);
    chk("base_a_hold", base_dat_a, 180);
    chk("base_b_hold", base_dat_b, 7);
    regaddr1 = 6;
    rw(6, 55);
    chk("base_same_old", base_dat_a, 180);
    @(negedge Clk);
    chk("base_same_new", base_dat_a, 55);
    regaddr1 = 8;
    @(negedge Clk);
    chk("base_a8", base_dat_a, 2);
    mem_init = 1;
    @(negedge Clk);
    mem_init = 0;
    chk("init_ready_low", {31'b0, ready}, 0);
    WR = 1; cpu_addr = 181; cpu_wdata = 77;
    rd(181, 2);
    WR = 0;
    chk("clear_rd_miss", dataIn1, MISS);
    chk("clear_rd_valid", {31'b0, rvalid}, 1);
    wait_ready(n);
    chk("reinit_latency", n, 127);
    rd(181, 2);
    chk("reinit_a181", dataIn1, 0);
    chk("reinit_b2", dataIn2, 0);
    mem_init = 1;
    @(negedge Clk);
    mem_init = 0; RD = 1; addr1 = 180;
    repeat (5) @(negedge Clk);
    chk("pre_rst_base_a", base_dat_a, 2);
    chk("pre_rst_rvalid", {31'b0, rvalid}, 1);
    #1 Rst = 0;
    #1;
    chk("arst_rvalid", {31'b0, rvalid}, 0);
    chk("arst_base_a", base_dat_a, 0);
    chk("arst_base_b", base_dat_b, 0);
    chk("arst_d1", dataIn1, MISS);
    chk("arst_ready", {31'b0, ready}, 0);
    RD = 0; regaddr1 = 0; regaddr2 = 0;
    #1 Rst = 1;
    wait_ready(n);
    chk("rst_sweep_latency", n, 128);
    regaddr1 = 6;
    @(negedge Clk);
    chk("rst_reg6_zero", base_dat_a, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
